delta_demodulator: RTL and testbench
====================================

# delta_demodulator

Receive-side counterpart of the delta-modulation encoder. It takes the 2-bit on/off spike stream and rebuilds a DATA_W-bit sample by adding or subtracting a programmable step in a saturating accumulator. An optional leak pulls the reconstruction toward a target level when no spikes arrive. It sits after the encoder, or on an off-chip spike link, and drives the reconstructed value to the output pins.

## Interface
- DATA_W, 4: width of the reconstructed sample.
- STEP_W, 4: width of the step magnitude.
- LEAK_W, 8: width of the leak period counter.
- LEAK_TARGET, 0: level the leak moves toward. Must be less than 2^DATA_W.

- clk, in, 1: single clock. Every register is on its rising edge.
- rst_n, in, 1: reset, synchronous and active-low.
- spike_in, in, 2: [1] is the on spike (increase), [0] is the off spike (decrease).
- step, in, STEP_W: step magnitude.
- load, in, 1: force the accumulator to load_value.
- load_value, in, DATA_W: value used by load.
- leak_period, in, LEAK_W: idle cycles per leak step. 0 disables the leak.
- recon, out, DATA_W: reconstructed sample.
- recon_valid, out, 1: one-cycle pulse when recon changes.
- sat, out, 1: sticky flag, an update clipped at 0 or at max.
- err, out, 1: sticky flag, on and off spikes arrived together.

## Operation
- **Input stage:** spike_in, step, load, load_value and leak_period are registered every cycle into the _q copies. All decisions use the registered copies only.
- **Update priority per cycle:** load_q, then spike, then leak. Only one source writes recon in a cycle.
- **load_q:** recon becomes load_value_q. sat and err clear. The leak counter clears.
- **spike_q = 2'b10:** recon becomes min(recon + step_q, 2^DATA_W - 1). Compute in DATA_W+1 bits. Set sat if the result clipped.
- **spike_q = 2'b01:** recon becomes max(recon - step_q, 0). Set sat if the true result was negative.
- **step_q = 0 with a spike:** recon holds, recon_valid stays low, and the spike still counts as accepted.
- **spike_q = 2'b11:** recon holds and err sets. This is not an accepted spike, so the leak counter keeps counting.
- **Leak counter:** increments on every cycle with no load_q and no accepted spike. It clears on load_q or on an accepted spike.
- **Leak step:** when leak_period_q ≠ 0 and the counter reaches leak_period_q - 1, recon moves 1 LSB toward LEAK_TARGET and the counter clears.
  - If recon already equals LEAK_TARGET, recon holds and the counter still clears.
  - The counter saturates at all-ones and never wraps.
  - When leak_period_q = 0 the counter holds at 0.
- **recon_valid:** registered alongside recon. It is 1 exactly in the cycle after any write that changed the value of recon.
- **Reset values:** recon=0, recon_valid=0, sat=0, err=0, leak counter=0, all _q registers=0. Reset asserted mid-stream overrides load, spike and leak in that cycle.

## Timing
- Latency: a spike present at edge N (captured into spike_q) updates recon at edge N+1. recon_valid is high in the cycle after edge N+1.
- Load has the same 2-edge latency.
- Back-to-back spikes on consecutive cycles give one update per cycle. There is no throughput limit.
- sat and err set on the same edge as the offending update. Only load_q or reset clears them.
- First leak step: with leak_period_q=P and the last accepted spike or load processed at edge M, recon steps at edge M+P. Later steps follow every P edges.
- A change to leak_period takes effect one edge after it is applied. The counter is not cleared by that change.

## Structure
- Package delta_pkg:
  - spike encoding constants SPIKE_NONE=2'b00, SPIKE_OFF=2'b01, SPIKE_ON=2'b10, SPIKE_BOTH=2'b11.
  - default DATA_W and STEP_W.
  - This package is shared with the encoder.
- Sub-module delta_sat_acc: combinational saturating add/sub.
  - Inputs: recon, step, direction.
  - Outputs: next value and clip flag.
- The top contains the input register stage, the priority mux, the leak counter and the flags.

## Test plan
All cases use DATA_W=4, STEP_W=4, LEAK_TARGET=0.

1. **Reset:** hold rst_n=0 for 2 cycles with spike_in=2'b10 and step=3 → recon=0, recon_valid=0, sat=0, err=0. Release → the first update appears 2 edges later.
2. **Tracking:** step=3, spike_in=2'b10 for 3 cycles → recon 3, 6, 9 on consecutive cycles, recon_valid high each cycle. Then 2'b01 for one cycle → recon 6.
3. **Saturation:**
   - load_value=14, then step=5 with an on spike → recon=15, sat=1.
   - load_value=2, then step=5 with an off spike → recon=0, sat=1.
   - Load clears sat.
4. **Conflict:** recon=9, spike_in=2'b11 → recon stays 9, recon_valid=0, err=1. err stays 1 through later spikes until a load.
5. **Leak:** load 3 with leak_period=4 and no spikes → recon 2, 1, 0 at 4-edge intervals, then holds at 0 with no recon_valid pulses. An on spike mid-sequence restarts the 4-edge interval.
6. **Priority and reset:**
   - load=1 with load_value=7 and spike_in=2'b10 in the same cycle → recon=7, not 7+step.
   - rst_n low in the same cycle as a pending update → recon=0, no valid pulse.

Source files
------------

// File: rtl/delta_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | delta_pkg : spike encoding and default widths for the delta link |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package delta_pkg;

   localparam int DEF_DATA_W = 4;
   localparam int DEF_STEP_W = 4;

   localparam logic [1:0] SPIKE_NONE = 2'b00;
   localparam logic [1:0] SPIKE_OFF  = 2'b01;
   localparam logic [1:0] SPIKE_ON   = 2'b10;
   localparam logic [1:0] SPIKE_BOTH = 2'b11;

endpackage
`default_nettype wire

// File: rtl/delta_demodulator_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | delta_demodulator_if : spike/control inputs and recon outputs    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface delta_demodulator_if
   import delta_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int STEP_W = DEF_STEP_W,
   parameter int LEAK_W = 8
) ();

   logic [1:0]        spike_in;
   logic [STEP_W-1:0] step;
   logic              load;
   logic [DATA_W-1:0] load_value;
   logic [LEAK_W-1:0] leak_period;
   logic [DATA_W-1:0] recon;
   logic              recon_valid;
   logic              sat;
   logic              err;

   modport master (
      output spike_in, step, load, load_value, leak_period,
      input  recon, recon_valid, sat, err
   );

   modport slave (
      input  spike_in, step, load, load_value, leak_period,
      output recon, recon_valid, sat, err
   );

endinterface
`default_nettype wire

// File: rtl/delta_sat_acc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | delta_sat_acc : combinational saturating add/subtract of a step  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module delta_sat_acc
   import delta_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int STEP_W = DEF_STEP_W
) (
   input  logic [DATA_W-1:0] recon,
   input  logic [STEP_W-1:0] step,
   input  logic              dir_up,
   output logic [DATA_W-1:0] next_val,
   output logic              clip
);

   // One guard bit above the wider operand keeps the overflow visible.
   localparam int SUM_W = ((DATA_W > STEP_W) ? DATA_W : STEP_W) + 1;
   localparam logic [SUM_W-1:0] MAX_VAL = {{(SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

   logic [SUM_W-1:0] recon_x;
   logic [SUM_W-1:0] step_x;
   logic [SUM_W-1:0] sum;

   assign recon_x = SUM_W'(recon);
   assign step_x  = SUM_W'(step);
   assign sum     = recon_x + step_x;

   always_comb begin
      next_val = recon;
      clip     = 1'b0;
      if (dir_up) begin
         if (sum > MAX_VAL) begin
            next_val = {DATA_W{1'b1}};
            clip     = 1'b1;
         end else begin
            next_val = DATA_W'(sum);
         end
      end else begin
         if (step_x > recon_x) begin
            next_val = '0;
            clip     = 1'b1;
         end else begin
            next_val = DATA_W'(recon_x - step_x);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/delta_demodulator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | delta_demodulator : rebuilds a sample from an on/off spike link  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module delta_demodulator
   import delta_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int STEP_W      = DEF_STEP_W,
   parameter int LEAK_W      = 8,
   parameter int LEAK_TARGET = 0
) (
   input logic                clk,
   input logic                rst_n,
   delta_demodulator_if.slave bus
);

   localparam logic [DATA_W-1:0] LEAK_TGT = DATA_W'(LEAK_TARGET);

   logic [1:0]        spike_q;
   logic [STEP_W-1:0] step_q;
   logic              load_q;
   logic [DATA_W-1:0] load_value_q;
   logic [LEAK_W-1:0] leak_period_q;

   logic [DATA_W-1:0] recon_q, recon_d;
   logic              recon_valid_q, recon_valid_d;
   logic              sat_q, sat_d;
   logic              err_q, err_d;
   logic [LEAK_W-1:0] leak_cnt_q, leak_cnt_d;

   logic              spike_accept;
   logic              dir_up;
   logic [DATA_W-1:0] acc_next;
   logic              acc_clip;

   assign spike_accept = (spike_q == SPIKE_ON) || (spike_q == SPIKE_OFF);
   assign dir_up       = (spike_q == SPIKE_ON);

   delta_sat_acc #(
      .DATA_W (DATA_W),
      .STEP_W (STEP_W)
   ) u_sat_acc (
      .recon    (recon_q),
      .step     (step_q),
      .dir_up   (dir_up),
      .next_val (acc_next),
      .clip     (acc_clip)
   );

   always_comb begin
      recon_d       = recon_q;
      recon_valid_d = 1'b0;
      sat_d         = sat_q;
      err_d         = err_q;
      leak_cnt_d    = leak_cnt_q;

      if (load_q) begin
         recon_d       = load_value_q;
         recon_valid_d = (load_value_q != recon_q);
         sat_d         = 1'b0;
         err_d         = 1'b0;
         leak_cnt_d    = '0;
      end else if (spike_accept) begin
         recon_d       = acc_next;
         recon_valid_d = (acc_next != recon_q);
         sat_d         = sat_q | acc_clip;
         leak_cnt_d    = '0;
      end else begin
         // A conflicting spike pair flags an error but does not restart the leak interval.
         if (spike_q == SPIKE_BOTH) begin
            err_d = 1'b1;
         end
         if (leak_period_q == '0) begin
            leak_cnt_d = '0;
         end else if (leak_cnt_q == leak_period_q - LEAK_W'(1)) begin
            leak_cnt_d = '0;
            if (recon_q > LEAK_TGT) begin
               recon_d       = recon_q - DATA_W'(1);
               recon_valid_d = 1'b1;
            end else if (recon_q < LEAK_TGT) begin
               recon_d       = recon_q + DATA_W'(1);
               recon_valid_d = 1'b1;
            end
         end else if (leak_cnt_q != {LEAK_W{1'b1}}) begin
            leak_cnt_d = leak_cnt_q + LEAK_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         spike_q       <= '0;
         step_q        <= '0;
         load_q        <= 1'b0;
         load_value_q  <= '0;
         leak_period_q <= '0;
         recon_q       <= '0;
         recon_valid_q <= 1'b0;
         sat_q         <= 1'b0;
         err_q         <= 1'b0;
         leak_cnt_q    <= '0;
      end else begin
         spike_q       <= bus.spike_in;
         step_q        <= bus.step;
         load_q        <= bus.load;
         load_value_q  <= bus.load_value;
         leak_period_q <= bus.leak_period;
         recon_q       <= recon_d;
         recon_valid_q <= recon_valid_d;
         sat_q         <= sat_d;
         err_q         <= err_d;
         leak_cnt_q    <= leak_cnt_d;
      end
   end

   assign bus.recon       = recon_q;
   assign bus.recon_valid = recon_valid_q;
   assign bus.sat         = sat_q;
   assign bus.err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_delta_demodulator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_delta_demodulator : vector table and scoreboard bench         |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_delta_demodulator;
   import delta_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   delta_demodulator_if #(.DATA_W(4), .STEP_W(4), .LEAK_W(8)) bus ();

   delta_demodulator #(
      .DATA_W      (4),
      .STEP_W      (4),
      .LEAK_W      (8),
      .LEAK_TARGET (0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [1:0] spike;
      logic [3:0] step;
      logic       load;
      logic [3:0] lval;
      logic [7:0] lper;
      logic [3:0] recon;
      logic       valid;
      logic       sat;
      logic       err;
   } vec_t;

   typedef struct {
      logic [3:0] recon;
      logic       valid;
      logic       sat;
      logic       err;
      int         due;
      int         idx;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   ecnt  = 0;

   function automatic vec_t mk(input logic [1:0] sp, input logic [3:0] st, input logic ld,
                               input logic [3:0] lv, input logic [7:0] lp, input logic [3:0] r,
                               input logic v, input logic s, input logic e);
      vec_t x;
      x.spike = sp; x.step = st; x.load = ld; x.lval = lv; x.lper = lp;
      x.recon = r;  x.valid = v; x.sat = s;   x.err = e;
      return x;
   endfunction

   task automatic check(input string name, input logic [3:0] r, input logic v,
                        input logic s, input logic e);
      n_vec++;
      if (bus.recon !== r || bus.recon_valid !== v || bus.sat !== s || bus.err !== e) begin
         n_bad++;
         $display("FAIL %s: got recon=%0d valid=%b sat=%b err=%b, want recon=%0d valid=%b sat=%b err=%b",
                  name, bus.recon, bus.recon_valid, bus.sat, bus.err, r, v, s, e);
      end
   endtask

   task automatic drive(input logic [1:0] sp, input logic [3:0] st, input logic ld,
                        input logic [3:0] lv, input logic [7:0] lp);
      bus.spike_in    = sp;
      bus.step        = st;
      bus.load        = ld;
      bus.load_value  = lv;
      bus.leak_period = lp;
   endtask

   // Advance one edge, then compare every scoreboard entry whose result is due now.
   task automatic tick();
      exp_t x;
      @(posedge clk);
      #1;
      ecnt++;
      while (sb.size() > 0 && sb[0].due == ecnt) begin
         x = sb.pop_front();
         check($sformatf("vec%0d", x.idx), x.recon, x.valid, x.sat, x.err);
      end
   endtask

   initial begin
      #200000;
      $display("watchdog expired at %0t", $time);
      $fatal(1, "bench did not terminate");
   end

   initial begin
      exp_t e;

      // tracking
      tbl.push_back(mk(SPIKE_ON,   3, 0, 0, 0,  3, 1, 0, 0));
      tbl.push_back(mk(SPIKE_ON,   3, 0, 0, 0,  6, 1, 0, 0));
      tbl.push_back(mk(SPIKE_ON,   3, 0, 0, 0,  9, 1, 0, 0));
      tbl.push_back(mk(SPIKE_OFF,  3, 0, 0, 0,  6, 1, 0, 0));
      tbl.push_back(mk(SPIKE_NONE, 3, 0, 0, 0,  6, 0, 0, 0));
      // saturation and zero step
      tbl.push_back(mk(SPIKE_NONE, 5, 1, 14, 0, 14, 1, 0, 0));
      tbl.push_back(mk(SPIKE_ON,   5, 0, 0, 0, 15, 1, 1, 0));
      tbl.push_back(mk(SPIKE_NONE, 5, 0, 0, 0, 15, 0, 1, 0));
      tbl.push_back(mk(SPIKE_NONE, 5, 1, 2, 0,  2, 1, 0, 0));
      tbl.push_back(mk(SPIKE_OFF,  5, 0, 0, 0,  0, 1, 1, 0));
      tbl.push_back(mk(SPIKE_ON,   0, 0, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(SPIKE_NONE, 0, 1, 9, 0,  9, 1, 0, 0));
      // conflict
      tbl.push_back(mk(SPIKE_BOTH, 3, 0, 0, 0,  9, 0, 0, 1));
      tbl.push_back(mk(SPIKE_ON,   3, 0, 0, 0, 12, 1, 0, 1));
      tbl.push_back(mk(SPIKE_OFF,  3, 0, 0, 0,  9, 1, 0, 1));
      tbl.push_back(mk(SPIKE_NONE, 3, 1, 9, 0,  9, 0, 0, 0));
      tbl.push_back(mk(SPIKE_NONE, 3, 0, 0, 0,  9, 0, 0, 0));
      // load beats spike
      tbl.push_back(mk(SPIKE_ON,   3, 1, 7, 0,  7, 1, 0, 0));
      tbl.push_back(mk(SPIKE_NONE, 3, 0, 0, 0,  7, 0, 0, 0));
      // leak toward 0 every 4 edges, then hold quietly
      tbl.push_back(mk(SPIKE_NONE, 0, 1, 3, 4,  3, 1, 0, 0));
      repeat (3) tbl.push_back(mk(SPIKE_NONE, 0, 0, 0, 4, 3, 0, 0, 0));
      for (int lvl = 2; lvl >= 0; lvl--) begin
         tbl.push_back(mk(SPIKE_NONE, 0, 0, 0, 4, 4'(lvl), 1, 0, 0));
         repeat (3) tbl.push_back(mk(SPIKE_NONE, 0, 0, 0, 4, 4'(lvl), 0, 0, 0));
      end
      repeat (5) tbl.push_back(mk(SPIKE_NONE, 0, 0, 0, 4, 0, 0, 0, 0));
      // spike restarts the interval; conflict does not
      tbl.push_back(mk(SPIKE_NONE, 0, 1, 3, 4,  3, 1, 0, 0));
      repeat (2) tbl.push_back(mk(SPIKE_NONE, 0, 0, 0, 4, 3, 0, 0, 0));
      tbl.push_back(mk(SPIKE_ON,   1, 0, 0, 4,  4, 1, 0, 0));
      repeat (3) tbl.push_back(mk(SPIKE_NONE, 1, 0, 0, 4, 4, 0, 0, 0));
      tbl.push_back(mk(SPIKE_NONE, 1, 0, 0, 4,  3, 1, 0, 0));
      tbl.push_back(mk(SPIKE_NONE, 1, 0, 0, 4,  3, 0, 0, 0));
      tbl.push_back(mk(SPIKE_BOTH, 1, 0, 0, 4,  3, 0, 0, 1));
      tbl.push_back(mk(SPIKE_NONE, 1, 0, 0, 4,  3, 0, 0, 1));
      tbl.push_back(mk(SPIKE_NONE, 1, 0, 0, 4,  2, 1, 0, 1));
      tbl.push_back(mk(SPIKE_NONE, 1, 0, 0, 0,  2, 0, 0, 1));
      tbl.push_back(mk(SPIKE_NONE, 1, 0, 0, 0,  2, 0, 0, 1));

      // reset held with a live spike, then first update two edges after release
      rst_n = 1'b0;
      drive(SPIKE_ON, 3, 0, 0, 0);
      tick(); check("rst_hold0", 0, 0, 0, 0);
      tick(); check("rst_hold1", 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();
      drive(SPIKE_NONE, 3, 0, 0, 0);
      check("rst_first_edge", 0, 0, 0, 0);
      tick(); check("rst_first_update", 3, 1, 0, 0);
      tick(); check("rst_after_update", 3, 0, 0, 0);
      rst_n = 1'b0;
      tick(); check("rst_again", 0, 0, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].spike, tbl[i].step, tbl[i].load, tbl[i].lval, tbl[i].lper);
         e.recon = tbl[i].recon; e.valid = tbl[i].valid;
         e.sat   = tbl[i].sat;   e.err   = tbl[i].err;
         e.due   = ecnt + 2;     e.idx   = i;
         sb.push_back(e);
         tick();
      end
      drive(SPIKE_NONE, 0, 0, 0, 0);
      for (int k = 0; k < 4 && sb.size() > 0; k++) tick();
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end

      // reset arriving while an update is pending
      drive(SPIKE_ON, 3, 0, 0, 0);
      tick();
      rst_n = 1'b0;
      drive(SPIKE_NONE, 3, 0, 0, 0);
      tick(); check("rst_mid_stream", 0, 0, 0, 0);
      rst_n = 1'b1;
      tick(); check("rst_mid_after0", 0, 0, 0, 0);
      tick(); check("rst_mid_after1", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
